// File: rtl/sdm_tx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// sdm_tx - second-order 1-bit delta-sigma modulator (bitstream source / 1-bit DAC)
//
// Signed PCM samples arrive over a valid/ready handshake into a single pending
// slot. Every OSR modulator steps the pending sample, if there is one, becomes
// the current sample. Each enabled clock (cen=1) runs one modulator step and
// emits one density-coded bit on dout.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cen        modulator step enable (the handshake capture ignores it)
//   din        signed PCM sample, WIN bits
//   din_valid  sample offered
//   din_ready  pending slot free (combinational from register state)
//   dout       registered modulator bit
//   tick       one-cycle pulse on the step that starts a new sample period
//   underrun   one-cycle pulse when a period starts with no pending sample
//   sat        sticky flag: an integrator has saturated since reset
//
// Build option:
//   SDM_DITHER_EN  when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                  seed 0xACE1) adds +/-1 LSB to the first integrator input
//                  on every step to break idle tones. When undefined there is
//                  no LFSR and the modulator is purely deterministic.
// -----------------------------------------------------------------------------
module sdm_tx #(
    parameter int unsigned WIN  = 16,
    parameter int unsigned OSR  = 24,
    parameter int unsigned WACC = WIN + 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic [WIN-1:0] din,
    input  logic           din_valid,
    output logic           din_ready,
    output logic           dout,
    output logic           tick,
    output logic           underrun,
    output logic           sat
);

    // Phase counter width; OSR is limited to 2..256 so 8 bits always suffice.
    localparam int unsigned CW = (OSR > 1) ? $clog2(OSR) : 1;
    // Working width for the integrator sums before saturation.
    localparam int unsigned SW = WACC + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

    // +FS = 2^(WIN-1), sign-extended to the working width.
    localparam logic signed [SW-1:0] FS_POS  = {{(SW - WIN){1'b0}}, 1'b1, {(WIN - 1){1'b0}}};
    localparam logic signed [SW-1:0] FS_NEG  = -FS_POS;
    // Symmetric saturation limits +/-(2^(WACC-1)-1).
    localparam logic signed [SW-1:0] ACC_MAX = {2'b00, {(WACC - 1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {2'b11, {(WACC - 2){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [WIN-1:0]  cur_q, cur_d;
    logic signed [WIN-1:0]  pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    logic signed [WACC-1:0] int1_q, int1_d;
    logic signed [WACC-1:0] int2_q, int2_d;
    logic                   dout_q, dout_d;
    logic                   tick_q, tick_d;
    logic                   und_q, und_d;
    logic                   sat_q, sat_d;

    // -------------------------------------------------------------------------
    // Saturation helpers
    // -------------------------------------------------------------------------
    function automatic logic acc_ovf(input logic signed [SW-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    function automatic logic signed [WACC-1:0] acc_clip(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] c;
        if (v > ACC_MAX) begin
            c = ACC_MAX;
        end else if (v < ACC_MIN) begin
            c = ACC_MIN;
        end else begin
            c = v;
        end
        return c[WACC-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Optional dither source
    // -------------------------------------------------------------------------
    logic signed [SW-1:0] dith;

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (cen) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // LSB 1 -> +1, LSB 0 -> -1 (all ones).
    assign dith = lfsr_q[0] ? {{(SW - 1){1'b0}}, 1'b1} : {SW{1'b1}};
`else
    assign dith = '0;
`endif

    // -------------------------------------------------------------------------
    // Modulator datapath (uses pre-edge dout for the feedback)
    // -------------------------------------------------------------------------
    logic                   boundary;
    logic                   xfer;
    logic signed [SW-1:0]   fb;
    logic signed [SW-1:0]   int1_ext;
    logic signed [SW-1:0]   int2_ext;
    logic signed [SW-1:0]   cur_ext;
    logic signed [SW-1:0]   sum1;
    logic signed [SW-1:0]   sum2;
    logic signed [WACC-1:0] int1_new;
    logic signed [SW-1:0]   int1_new_ext;
    logic signed [WACC-1:0] int2_new;
    logic                   ovf1;
    logic                   ovf2;

    assign boundary = cen & (cnt_q == CNT_LAST);
    assign xfer     = din_valid & ~pend_full_q;

    assign fb       = dout_q ? FS_POS : FS_NEG;
    assign int1_ext = {{(SW - WACC){int1_q[WACC-1]}}, int1_q};
    assign int2_ext = {{(SW - WACC){int2_q[WACC-1]}}, int2_q};
    assign cur_ext  = {{(SW - WIN){cur_q[WIN-1]}}, cur_q};

    // One extra bit is enough: int2 can only approach a rail while dout points
    // the feedback away from that rail, so neither sum leaves the SW-bit range.
    assign sum1         = int1_ext + cur_ext - fb + dith;
    assign ovf1         = acc_ovf(sum1);
    assign int1_new     = acc_clip(sum1);
    assign int1_new_ext = {{(SW - WACC){int1_new[WACC-1]}}, int1_new};

    assign sum2     = int2_ext + int1_new_ext - fb;
    assign ovf2     = acc_ovf(sum2);
    assign int2_new = acc_clip(sum2);

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        int1_d      = int1_q;
        int2_d      = int2_q;
        dout_d      = dout_q;
        sat_d       = sat_q;
        tick_d      = boundary;
        und_d       = boundary & ~pend_full_q;

        if (cen) begin
            int1_d = int1_new;
            int2_d = int2_new;
            dout_d = ~int2_new[WACC-1];
            sat_d  = sat_q | ovf1 | ovf2;
            cnt_d  = boundary ? '0 : cnt_q + CW'(1);
        end

        // Old pending moves to current before a same-edge transfer refills it.
        if (boundary && pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
        end

        if (xfer) begin
            pend_d      = din;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cur_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            int1_q      <= '0;
            int2_q      <= '0;
            dout_q      <= 1'b0;
            tick_q      <= 1'b0;
            und_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            int1_q      <= int1_d;
            int2_q      <= int2_d;
            dout_q      <= dout_d;
            tick_q      <= tick_d;
            und_q       <= und_d;
            sat_q       <= sat_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign din_ready = ~pend_full_q;
    assign dout      = dout_q;
    assign tick      = tick_q;
    assign underrun  = und_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_sdm_tx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_sdm_tx - self-checking bench for sdm_tx.
// A behavioural model (integers, a sample queue, a step counter since reset)
// predicts din_ready, dout, tick, underrun and sat on every clock. A table of
// the known zero-input bit pattern and hand-written sequences cover reset,
// density, cen gating, saturation and mid-period reset.
// -----------------------------------------------------------------------------
module tb_sdm_tx;

    localparam int WIN  = 16;
    localparam int OSR  = 24;
    localparam int WACC = WIN + 4;

    localparam longint FS  = 64'sd1 <<< (WIN - 1);
    localparam longint LIM = (64'sd1 <<< (WACC - 1)) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cen = 1'b0;
    logic [WIN-1:0]  din = '0;
    logic            din_valid = 1'b0;
    logic            din_ready;
    logic            dout;
    logic            tick;
    logic            underrun;
    logic            sat;

    always #5 clk = ~clk;

    sdm_tx #(
        .WIN  (WIN),
        .OSR  (OSR),
        .WACC (WACC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .tick      (tick),
        .underrun  (underrun),
        .sat       (sat)
    );

    int checks = 0;
    int errors = 0;

    // Counters of DUT activity since the last reset.
    int n_xfer = 0;
    int n_tick = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    longint      m_int1, m_int2, m_cur;
    longint      m_pend[$];
    bit          m_dout, m_tick, m_und, m_sat;
    int          m_steps;
    bit [15:0]   m_lfsr;

    function automatic longint clip(longint v);
        if (v > LIM) begin
            m_sat = 1'b1;
            return LIM;
        end
        if (v < -LIM) begin
            m_sat = 1'b1;
            return -LIM;
        end
        return v;
    endfunction

    task automatic m_reset();
        m_int1 = 0; m_int2 = 0; m_cur = 0;
        m_pend.delete();
        m_dout = 0; m_tick = 0; m_und = 0; m_sat = 0;
        m_steps = 0;
        m_lfsr = 16'hACE1;
    endtask

    // One clock edge with the given pre-edge inputs.
    task automatic m_edge(input bit c, input bit v, input logic [WIN-1:0] d);
        longint fb, dth;
        bit     ready;
        ready  = (m_pend.size() == 0);
        m_tick = 0;
        m_und  = 0;
        if (c) begin
            dth = 0;
`ifdef SDM_DITHER_EN
            dth = m_lfsr[0] ? 1 : -1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
            fb     = m_dout ? FS : -FS;
            m_int1 = clip(m_int1 + m_cur - fb + dth);
            m_int2 = clip(m_int2 + m_int1 - fb);
            m_dout = (m_int2 >= 0);
            m_steps++;
            // Every OSR-th enabled step since reset closes a sample period.
            if (m_steps % OSR == 0) begin
                m_tick = 1;
                if (m_pend.size() > 0) m_cur = m_pend.pop_front();
                else m_und = 1;
            end
        end
        if (v && ready) m_pend.push_back(longint'($signed(d)));
    endtask

    // Apply inputs for one clock, compare everything against the model.
    task automatic step(input bit c, input bit v, input logic [WIN-1:0] d);
        cen = c;
        din_valid = v;
        din = d;
        chk("din_ready", din_ready, m_pend.size() == 0);
        if (v && din_ready) n_xfer++;
        @(posedge clk);
        #1;
        m_edge(c, v, d);
        chk("dout", dout, m_dout);
        chk("tick", tick, m_tick);
        chk("underrun", underrun, m_und);
        chk("sat", sat, m_sat);
        if (tick) n_tick++;
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        cen = 1'b0;
        din_valid = 1'b0;
        din = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_tick", tick, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_sat", sat, 0);
        chk("rst_ready", din_ready, 1);
        m_reset();
        n_xfer = 0;
        n_tick = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", din_ready, 1);
    endtask

`ifndef SDM_DITHER_EN
    typedef struct {
        bit             cen;
        bit             valid;
        logic [WIN-1:0] din;
        bit             exp_dout;
        bit             exp_tick;
        bit             exp_und;
    } vec_t;

    vec_t tab[12];
    bit   zero_pat[12] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};

    // Zero input from reset: fixed bit pattern, underrun every OSR steps.
    task automatic zero_test();
        int ones;
        ones = 0;
        for (int i = 0; i < 12; i++) begin
            step(tab[i].cen, tab[i].valid, tab[i].din);
            chk("zero_dout", dout, tab[i].exp_dout);
            chk("zero_tick", tick, tab[i].exp_tick);
            chk("zero_und", underrun, tab[i].exp_und);
            if (i + 1 >= 5) ones += int'(dout);
        end
        for (int k = 13; k <= 48; k++) begin
            step(1'b1, 1'b0, '0);
            chk("zero_und_period", underrun, (k % 24) == 0);
            chk("zero_tick_period", tick, (k % 24) == 0);
            if (k <= 28) ones += int'(dout);
        end
        chk("zero_ones_in_24", ones, 12);
    endtask
`endif

    // Constant input offered continuously; density measured after 2nd boundary.
    task automatic density(input string name, input logic [WIN-1:0] val, input int lo,
                           input int hi);
        int ones;
        do_reset();
        ones = 0;
        for (int k = 1; k <= 288; k++) begin
            step(1'b1, 1'b1, val);
            if (k > 48) ones += int'(dout);
        end
        chk_range(name, ones, lo, hi);
        // First accept at step 1, then one refill after each of 11 boundaries.
        chk("density_xfers", n_xfer, 12);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [WIN-1:0] val;
        bit             c, v, acc;
        int             ones;

`ifndef SDM_DITHER_EN
        for (int i = 0; i < 12; i++) begin
            tab[i] = '{cen: 1'b1, valid: 1'b0, din: '0, exp_dout: zero_pat[i],
                       exp_tick: 1'b0, exp_und: 1'b0};
        end
`endif

        // Power-on reset.
        do_reset();
`ifndef SDM_DITHER_EN
        zero_test();
`endif

        density("density_half_pos", 16'h4000, 178, 182);
        density("density_half_neg", 16'hC000, 58, 62);

        // cen 1-of-3 with offers only on cen=0 cycles.
        do_reset();
        val = 16'h0100;
        for (int i = 0; i < 150; i++) begin
            c   = (i % 3) == 0;
            v   = !c;
            acc = v && din_ready;
            step(c, v, val);
            if (acc) val = val + 16'h0100;
        end
        chk("cen_gated_ticks", n_tick, 2);
        chk("cen0_xfers", n_xfer, 3);

        // Random enable/valid with a rising sample sequence.
        do_reset();
        val = 16'hC568;
        for (int i = 0; i < 1500; i++) begin
            c   = $urandom_range(0, 3) != 0;
            v   = $urandom_range(0, 1) != 0;
            acc = v && din_ready;
            step(c, v, val);
            if (acc) val = val + WIN'($urandom_range(1, 300));
        end

        // Near full-scale input drives the integrators into saturation.
        do_reset();
        ones = 0;
        for (int k = 1; k <= 400; k++) begin
            step(1'b1, 1'b1, 16'h7FFF);
            if (k > 100) ones += int'(dout);
        end
        chk("sat_sticky", sat, 1);
        chk_range("sat_density", ones, 285, 300);
        chk("pending_full_mid_period", din_ready, 0);

        // Mid-period reset with pending full, then zero-input restart.
        do_reset();
`ifndef SDM_DITHER_EN
        zero_test();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdm_tx.md
Name: sdm_tx

Overview:
- Second-order 1-bit delta-sigma modulator: the encode side of the bitstream that the team's sinc decimation filter decodes.
- Accepts signed PCM samples over a valid/ready handshake and holds each sample for OSR modulator steps.
- Emits a 1-bit density-coded stream, one bit per enabled clock.
- Used in benches as a bitstream source for filter/DAC checks, and as the synthesizable 1-bit DAC front end.

Parameters:
- WIN, 16: input sample width, signed two's complement; FS = 2^(WIN-1).
- OSR, 24: modulator steps per input sample; legal range 2..256.
- WACC, WIN+4: integrator width, signed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  modulator step enable; all state except the handshake capture advances only when cen=1.
- din  in  WIN  signed PCM sample.
- din_valid  in  1  sample offered.
- din_ready  out  1  pending slot free.
- dout  out  1  modulator bit, registered.
- tick  out  1  one-cycle pulse on the step that loads a new sample period.
- underrun  out  1  one-cycle pulse when a period starts with no pending sample.
- sat  out  1  sticky: an integrator saturated since reset.

Behaviour:
- Reset (async, rst_n=0): dout=0, tick=0, underrun=0, sat=0, int1=int2=0, phase counter=0, current sample=0, pending empty. din_ready=1 the first clock after release.
- Handshake:
  - One pending register plus one current register.
  - din_ready = !pending_full, combinational from the register state.
  - A transfer occurs on any clk edge with din_valid & din_ready, independent of cen.
- Phase counter:
  - Counts 0..OSR-1 on cen steps and wraps to 0.
  - On a cen step with counter==OSR-1, a period boundary occurs:
    - If pending is full: current<=pending, pending cleared, tick=1.
    - If pending is empty: current retained, tick=1, underrun=1.
  - Boundary and transfer on the same edge: the old pending moves to current and the new din fills pending. din_ready stays 1 in that cycle because it is derived from pre-edge state.
  - The first period starts at counter 0 after reset with current=0.
- Modulator step, on each cen=1 edge, using pre-edge dout:
  - fb = dout ? +FS : -FS.
  - int1' = sat(int1 + current - fb).
  - int2' = sat(int2 + int1' - fb).
  - dout <= (int2' >= 0).
- Arithmetic:
  - All arithmetic is signed at WACC+1 bits, then saturated to [-(2^(WACC-1)-1), 2^(WACC-1)-1].
  - Any saturation sets sat; only reset clears it.
- cen=0: counter, integrators and dout hold; tick and underrun stay 0.
- Latency: a sample accepted into an empty pending slot takes effect at the next period boundary. It first influences dout one cen step after that boundary.
- Zero-input steady state:
  - dout sequence from reset is 1,1,0,1,0,0,1,1, then a repeating 0,0,1,1 pattern.
  - Any 24 consecutive bits after step 4 contain exactly 12 ones.
- Reset mid-operation: all state is cleared immediately, and a pending sample is discarded.

Optional Feature:
- SDM_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset) advances on each cen step.
  - Its LSB adds +1 or -1 LSB (bit 1 → +1, bit 0 → -1) to the int1 input sum.
  - This breaks idle tones.
- SDM_DITHER_EN undefined: no LFSR, and the behaviour is exactly as above. The zero-input pattern checks apply only in this build.

Test Plan:
- Reset, cen=1 tied, din_valid=0: dout matches 1,1,0,1,0,0,1,1,0,0,1,1…; underrun pulses every 24 cycles; first pulse at cycle 24.
- Push din=+FS/2 (0x4000) then hold: over 240 steps after the second boundary, ones count = 180 ±2. Same test with -FS/2: count = 60 ±2.
- din_valid held high with a rising sample sequence: din_ready drops after one accept and reasserts for exactly one transfer per 24-step period. No sample is lost or duplicated; checked by the sinc-filter bench against a golden list.
- cen toggled 1-of-3: dout, tick and counter advance only on cen cycles, while a handshake transfer completes on a cen=0 cycle.
- Inject din=0x7FFF repeatedly: sat asserts and stays 1; no integrator wraps, since dout density stays ≥0.95.
- Assert rst_n low mid-period with pending full: outputs cleared asynchronously; after release din_ready=1 and the zero-input sequence restarts from the first bit.
